// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU sweep checker: command codes, FSM states,
// delay-line entry layout and command-mask walking helpers.
package alu_pkg;

  localparam int unsigned CMD_W = 3;
  localparam int unsigned DAT_W = 4;
  localparam int unsigned CNT_W = 12;

  localparam logic [CMD_W-1:0] CMD_ADD = 3'b000;
  localparam logic [CMD_W-1:0] CMD_SUB = 3'b001;
  localparam logic [CMD_W-1:0] CMD_NOT = 3'b010;
  localparam logic [CMD_W-1:0] CMD_AND = 3'b011;
  localparam logic [CMD_W-1:0] CMD_OR  = 3'b100;
  localparam logic [CMD_W-1:0] CMD_XOR = 3'b101;
  localparam logic [CMD_W-1:0] CMD_LT  = 3'b110;
  localparam logic [CMD_W-1:0] CMD_EQ  = 3'b111;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_e;

  typedef struct packed {
    logic             valid;
    logic [CMD_W-1:0] cmd;
    logic [DAT_W-1:0] a;
    logic [DAT_W-1:0] b;
    logic [DAT_W-1:0] exp_ans;
    logic             exp_ovf;
    logic             chk_ovf;
  } chk_entry_t;

  // Lowest enabled command in the mask.
  function automatic logic [CMD_W-1:0] first_cmd(input logic [7:0] mask);
    logic [CMD_W-1:0] res;
    res = '0;
    for (int k = 7; k >= 0; k--) begin
      if (mask[k]) res = CMD_W'(k);
    end
    return res;
  endfunction

  // {found, cmd}: lowest enabled command strictly above cur.
  function automatic logic [CMD_W:0] next_cmd(input logic [7:0] mask, input logic [CMD_W-1:0] cur);
    logic [CMD_W:0] res;
    res = '0;
    for (int k = 7; k >= 0; k--) begin
      if (mask[k] && (CMD_W'(k) > cur)) res = {1'b1, CMD_W'(k)};
    end
    return res;
  endfunction

endpackage

// File: rtl/alu_golden.sv
// Combinational golden model of the 4-bit, 8-command ALU.
module alu_golden
  import alu_pkg::*;
(
  input  logic [CMD_W-1:0] cmd_i,
  input  logic [DAT_W-1:0] a_i,
  input  logic [DAT_W-1:0] b_i,
  output logic [DAT_W-1:0] exp_ans_c,
  output logic             exp_ovf_c,
  output logic             chk_ovf_c
);

  logic [DAT_W-1:0] nb;
  logic [DAT_W:0]   sum;

  always_comb begin
    exp_ans_c = '0;
    exp_ovf_c = 1'b0;
    chk_ovf_c = 1'b0;
    nb        = DAT_W'(~b_i + 4'd1);
    sum       = (DAT_W+1)'(a_i) + (DAT_W+1)'(nb);
    case (cmd_i)
      CMD_ADD: exp_ans_c = DAT_W'(a_i + b_i);
      // Overflow is the carry out of a + two's-complement(b); b=0 gives nb=0, hence no carry.
      CMD_SUB: begin
        exp_ans_c = sum[DAT_W-1:0];
        exp_ovf_c = sum[DAT_W];
        chk_ovf_c = 1'b1;
      end
      CMD_NOT: exp_ans_c = ~a_i;
      CMD_AND: exp_ans_c = a_i & b_i;
      CMD_OR:  exp_ans_c = a_i | b_i;
      CMD_XOR: exp_ans_c = a_i ^ b_i;
      CMD_LT:  exp_ans_c = {3'b000, ($signed(a_i) < $signed(b_i))};
      CMD_EQ:  exp_ans_c = {3'b000, (a_i == b_i)};
      default: exp_ans_c = '0;
    endcase
  end

endmodule

// File: rtl/alu_sweep_checker.sv
// Exhaustive ALU sweep sequencer: issues every enabled (cmd, a, b) vector, compares the
// ALU result LAT cycles later against the golden model and records pass/fail statistics.
module alu_sweep_checker
  import alu_pkg::*;
#(
  parameter int unsigned LAT      = 1,
  parameter logic [7:0]  CMD_MASK = 8'hFF
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [CMD_W-1:0] cmd_o,
  output logic [DAT_W-1:0] a_o,
  output logic [DAT_W-1:0] b_o,
  input  logic [DAT_W-1:0] ans_i,
  input  logic             ovf_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic             err_valid,
  output logic [CMD_W-1:0] first_err_cmd,
  output logic [DAT_W-1:0] first_err_a,
  output logic [DAT_W-1:0] first_err_b
);

  localparam int unsigned DW = 3;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic [DAT_W-1:0] a_q, a_d, b_q, b_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic             issue_d, clr_c;
  logic [CMD_W:0]   nxt_c;
  logic [CNT_W-1:0] err_q, err_d;
  logic             err_valid_q, err_valid_d;
  logic [CMD_W-1:0] fe_cmd_q, fe_cmd_d;
  logic [DAT_W-1:0] fe_a_q, fe_a_d, fe_b_q, fe_b_d;
  logic             pass_q, pass_d, busy_q, done_q;
  logic [DAT_W-1:0] gold_ans_c;
  logic             gold_ovf_c, gold_chk_c, mismatch_c;
  chk_entry_t       ent_d, ret_c;
  chk_entry_t       pipe_q [LAT];

  // Golden result is computed on the vector being loaded so it enters the delay line with it.
  alu_golden u_golden (
    .cmd_i     (cmd_d),
    .a_i       (a_d),
    .b_i       (b_d),
    .exp_ans_c (gold_ans_c),
    .exp_ovf_c (gold_ovf_c),
    .chk_ovf_c (gold_chk_c)
  );

  // Sequencer: state transitions and vector walk (cmd outer, a middle, b inner).
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    a_d     = a_q;
    b_d     = b_q;
    drain_d = drain_q;
    issue_d = 1'b0;
    clr_c   = 1'b0;
    nxt_c   = next_cmd(CMD_MASK, cmd_q);
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          clr_c = 1'b1;
          if (CMD_MASK == 8'h00) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
            cmd_d   = first_cmd(CMD_MASK);
            a_d     = '0;
            b_d     = '0;
            issue_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        issue_d = 1'b1;
        if (b_q != 4'hF) begin
          b_d = b_q + 4'd1;
        end else if (a_q != 4'hF) begin
          a_d = a_q + 4'd1;
          b_d = '0;
        end else if (nxt_c[CMD_W]) begin
          cmd_d = nxt_c[CMD_W-1:0];
          a_d   = '0;
          b_d   = '0;
        end else begin
          issue_d = 1'b0;
          state_d = ST_DRAIN;
          drain_d = '0;
        end
      end
      ST_DRAIN: begin
        if (drain_q == DW'(LAT - 1)) state_d = ST_DONE;
        else                         drain_d = drain_q + DW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ent_d.valid   = issue_d;
    ent_d.cmd     = cmd_d;
    ent_d.a       = a_d;
    ent_d.b       = b_d;
    ent_d.exp_ans = gold_ans_c;
    ent_d.exp_ovf = gold_ovf_c;
    ent_d.chk_ovf = gold_chk_c;
  end

  assign ret_c      = pipe_q[LAT-1];
  assign mismatch_c = ret_c.valid &&
                      ((ans_i != ret_c.exp_ans) || (ret_c.chk_ovf && (ovf_i != ret_c.exp_ovf)));

  // Error statistics; the first mismatch is captured on the same edge it is counted.
  always_comb begin
    err_d       = err_q;
    err_valid_d = err_valid_q;
    fe_cmd_d    = fe_cmd_q;
    fe_a_d      = fe_a_q;
    fe_b_d      = fe_b_q;
    pass_d      = pass_q;
    if (clr_c) begin
      err_d       = '0;
      err_valid_d = 1'b0;
      fe_cmd_d    = '0;
      fe_a_d      = '0;
      fe_b_d      = '0;
      pass_d      = (CMD_MASK == 8'h00);
    end else if (mismatch_c) begin
      if (err_q != CNT_MAX) err_d = err_q + CNT_W'(1);
      if (!err_valid_q) begin
        err_valid_d = 1'b1;
        fe_cmd_d    = ret_c.cmd;
        fe_a_d      = ret_c.a;
        fe_b_d      = ret_c.b;
      end
    end
    if ((state_q == ST_DRAIN) && (state_d == ST_DONE)) pass_d = (err_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      drain_q     <= '0;
      err_q       <= '0;
      err_valid_q <= 1'b0;
      fe_cmd_q    <= '0;
      fe_a_q      <= '0;
      fe_b_q      <= '0;
      pass_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < LAT; i++) pipe_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      a_q         <= a_d;
      b_q         <= b_d;
      drain_q     <= drain_d;
      err_q       <= err_d;
      err_valid_q <= err_valid_d;
      fe_cmd_q    <= fe_cmd_d;
      fe_a_q      <= fe_a_d;
      fe_b_q      <= fe_b_d;
      pass_q      <= pass_d;
      busy_q      <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
      done_q      <= (state_d == ST_DONE);
      pipe_q[0]   <= ent_d;
      for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign cmd_o         = cmd_q;
  assign a_o           = a_q;
  assign b_o           = b_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_count     = err_q;
  assign err_valid     = err_valid_q;
  assign first_err_cmd = fe_cmd_q;
  assign first_err_a   = fe_a_q;
  assign first_err_b   = fe_b_q;

endmodule

// File: tb/tb_alu_sweep_checker.sv
// Bench for alu_sweep_checker: behavioural ALU models with fault injection, a vector-order
// scoreboard, and end-of-sweep checks on timing, pass/fail and first-error capture.
module tb_alu_sweep_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start1, start3, start0;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [2:0] cmd1, cmd3, cmd0, fc1, fc3, fc0;
  logic [3:0] a1, b1, a3, b3, a0, b0, ans1, ans3, ans0, fa1, fb1, fa3, fb3, fa0, fb0;
  logic       ovf1, ovf3, ovf0, busy1, busy3, busy0, done1, done3, done0;
  logic       pass1, pass3, pass0, ev1, ev3, ev0;
  logic [11:0] err1, err3, err0;

  logic       flt_en, flt_ovf, three_stage;
  logic [2:0] flt_cmd;
  logic [3:0] flt_a, flt_b, flt_ans;
  logic [4:0] r1, r3, s1, s2, r0;
  logic [10:0] q1 [$];
  logic [10:0] q3 [$];

  typedef struct packed {
    logic       en;
    logic [2:0] c;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] ans;
    logic       ovf;
    logic       ep;
  } row_t;
  row_t rows [8];

  alu_sweep_checker #(.LAT(1), .CMD_MASK(8'hFF)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .cmd_o(cmd1), .a_o(a1), .b_o(b1),
    .ans_i(ans1), .ovf_i(ovf1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .err_valid(ev1), .first_err_cmd(fc1), .first_err_a(fa1), .first_err_b(fb1));

  alu_sweep_checker #(.LAT(3), .CMD_MASK(8'h80)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .cmd_o(cmd3), .a_o(a3), .b_o(b3),
    .ans_i(ans3), .ovf_i(ovf3), .busy(busy3), .done(done3), .pass(pass3),
    .err_count(err3), .err_valid(ev3), .first_err_cmd(fc3), .first_err_a(fa3), .first_err_b(fb3));

  alu_sweep_checker #(.LAT(1), .CMD_MASK(8'h00)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .cmd_o(cmd0), .a_o(a0), .b_o(b0),
    .ans_i(ans0), .ovf_i(ovf0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .err_valid(ev0), .first_err_cmd(fc0), .first_err_a(fa0), .first_err_b(fb0));

  // Reference ALU: returns {ovf, ans}; SUB overflow is "no borrow and b nonzero".
  function automatic logic [4:0] ref_alu(input logic [2:0] c, input logic [3:0] a, input logic [3:0] b);
    logic [3:0] r;
    logic       o;
    r = '0;
    o = 1'b0;
    case (c)
      3'd0: r = 4'(a + b);
      3'd1: begin r = 4'(a - b); o = (a >= b) && (b != 4'd0); end
      3'd2: r = ~a;
      3'd3: r = a & b;
      3'd4: r = a | b;
      3'd5: r = a ^ b;
      3'd6: r = {3'b000, ({~a[3], a[2:0]} < {~b[3], b[2:0]})};
      default: r = {3'b000, (a == b)};
    endcase
    return {o, r};
  endfunction

  always_comb begin
    r1 = ref_alu(cmd1, a1, b1);
    if (flt_en && (cmd1 == flt_cmd) && (a1 == flt_a) && (b1 == flt_b)) r1 = {flt_ovf, flt_ans};
  end
  assign {ovf1, ans1} = r1;

  assign r3 = ref_alu(cmd3, a3, b3);
  always @(posedge clk) begin
    s1 <= r3;
    s2 <= s1;
  end
  assign {ovf3, ans3} = three_stage ? s2 : r3;

  assign r0 = ref_alu(cmd0, a0, b0);
  assign {ovf0, ans0} = r0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Scoreboard: vectors expected on the bus, in order, one per busy cycle.
  always @(negedge clk) begin
    if (busy1 && (q1.size() > 0)) check_eq("vec1", {53'd0, cmd1, a1, b1}, {53'd0, q1.pop_front()});
    if (busy3 && (q3.size() > 0)) check_eq("vec3", {53'd0, cmd3, a3, b3}, {53'd0, q3.pop_front()});
  end

  function automatic logic [37:0] outs1();
    return {busy1, done1, pass1, ev1, err1, fc1, fa1, fb1, cmd1, a1, b1};
  endfunction

  function automatic logic done_of(input int sel);
    return (sel == 1) ? done1 : (sel == 3) ? done3 : done0;
  endfunction

  task automatic push_vecs(input int sel, input logic [7:0] mask);
    for (int c = 0; c < 8; c++) begin
      if (mask[c]) begin
        for (int a = 0; a < 16; a++) begin
          for (int b = 0; b < 16; b++) begin
            if (sel == 1) q1.push_back({3'(c), 4'(a), 4'(b)});
            else          q3.push_back({3'(c), 4'(a), 4'(b)});
          end
        end
      end
    end
  endtask

  // Pulse start, then count cycles to done; optional mid-run start pulse or reset hit.
  task automatic sweep(input int sel, input int mid_start, input int rst_at, output int cyc);
    @(negedge clk);
    if (sel == 1) begin push_vecs(1, 8'hFF); start1 = 1'b1; end
    else if (sel == 3) begin push_vecs(3, 8'h80); start3 = 1'b1; end
    else start0 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start3 = 1'b0; start0 = 1'b0;
    cyc = 1;
    while (!done_of(sel) && (cyc < 5000)) begin
      start1 = (sel == 1) && (cyc == mid_start);
      if (cyc == rst_at) begin
        check_eq("pre_rst_err", 64'(err1), 64'd1);
        rst = 1'b1;
        #1;
        check_eq("rst_mid_outs", 64'(outs1()), 64'd0);
        repeat (2) @(negedge clk);
        check_eq("rst_hold_outs", 64'(outs1()), 64'd0);
        rst = 1'b0;
        q1.delete();
        cyc = -1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    start1 = 1'b0;
    if ((cyc >= 0) && !done_of(sel)) check_eq("done_timeout", 64'(cyc), 64'd0);
  endtask

  int cyc;

  initial begin
    rst = 1'b1; start1 = 1'b0; start3 = 1'b0; start0 = 1'b0;
    flt_en = 1'b0; flt_cmd = '0; flt_a = '0; flt_b = '0; flt_ans = '0; flt_ovf = 1'b0;
    three_stage = 1'b1;
    rows[0] = '{1'b0, 3'd0, 4'd0,  4'd0,  4'd0,  1'b0, 1'b1};
    rows[1] = '{1'b1, 3'd1, 4'd5,  4'd3,  4'd2,  1'b0, 1'b0};
    rows[2] = '{1'b1, 3'd1, 4'd3,  4'd5,  4'd14, 1'b1, 1'b0};
    rows[3] = '{1'b1, 3'd1, 4'd7,  4'd0,  4'd7,  1'b1, 1'b0};
    rows[4] = '{1'b1, 3'd1, 4'd5,  4'd3,  4'd3,  1'b1, 1'b0};
    rows[5] = '{1'b1, 3'd6, 4'd8,  4'd1,  4'd0,  1'b0, 1'b0};
    rows[6] = '{1'b1, 3'd0, 4'd15, 4'd15, 4'd14, 1'b1, 1'b1};
    rows[7] = '{1'b1, 3'd7, 4'd15, 4'd15, 4'd0,  1'b0, 1'b0};

    repeat (3) @(negedge clk);
    check_eq("rst_outs1", 64'(outs1()), 64'd0);
    check_eq("rst_outs3", {60'd0, busy3, done3, pass3, ev3}, 64'd0);
    check_eq("rst_outs0", {60'd0, busy0, done0, pass0, ev0}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_hold", {62'd0, busy1, done1}, 64'd0);

    for (int r = 0; r < 8; r++) begin
      flt_en = rows[r].en; flt_cmd = rows[r].c; flt_a = rows[r].a; flt_b = rows[r].b;
      flt_ans = rows[r].ans; flt_ovf = rows[r].ovf;
      sweep(1, -1, -1, cyc);
      check_eq($sformatf("cyc_r%0d", r), 64'(cyc), 64'd2050);
      check_eq($sformatf("pass_r%0d", r), 64'(pass1), 64'(rows[r].ep));
      check_eq($sformatf("err_r%0d", r), 64'(err1), rows[r].ep ? 64'd0 : 64'd1);
      check_eq($sformatf("first_r%0d", r), {52'd0, ev1, fc1, fa1, fb1},
               rows[r].ep ? 64'd0 : {52'd0, 1'b1, rows[r].c, rows[r].a, rows[r].b});
      check_eq($sformatf("q_empty_r%0d", r), 64'(q1.size()), 64'd0);
    end

    // Reset mid-sweep after an error was captured, then a clean sweep with a stray start.
    flt_en = 1'b1; flt_cmd = 3'd1; flt_a = 4'd5; flt_b = 4'd3; flt_ans = 4'd2; flt_ovf = 1'b0;
    sweep(1, -1, 500, cyc);
    flt_en = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("post_rst_quiet", 64'(outs1()), 64'd0);
    sweep(1, 300, -1, cyc);
    check_eq("cyc_restart", 64'(cyc), 64'd2050);
    check_eq("pass_restart", 64'(pass1), 64'd1);
    check_eq("err_restart", {51'd0, ev1, err1}, 64'd0);
    check_eq("q_empty_restart", 64'(q1.size()), 64'd0);

    three_stage = 1'b1;
    sweep(3, -1, -1, cyc);
    check_eq("cyc_lat3", 64'(cyc), 64'd260);
    check_eq("pass_lat3", 64'(pass3), 64'd1);
    check_eq("err_lat3", 64'(err3), 64'd0);
    check_eq("q_empty_lat3", 64'(q3.size()), 64'd0);

    three_stage = 1'b0;
    sweep(3, -1, -1, cyc);
    check_eq("cyc_lat3_short", 64'(cyc), 64'd260);
    check_eq("pass_lat3_short", 64'(pass3), 64'd0);
    check_eq("ev_lat3_short", 64'(ev3), 64'd1);

    sweep(0, -1, -1, cyc);
    check_eq("cyc_mask0", 64'(cyc), 64'd1);
    check_eq("pass_mask0", {51'd0, pass0, err0}, {51'd0, 1'b1, 12'd0});
    check_eq("busy_mask0", 64'(busy0), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_sweep_checker.md
# alu_sweep_checker

Sequencer and checker that exhaustively drives the 4-bit, 8-command ALU and checks every result against an internal golden model. It sits on the far side of the ALU's command/operand/result interface: it generates `command`/`a`/`b`, reads back `ans`/`overflow_flag`, and reports pass/fail, the mismatch count and the first failing vector. It serves as on-board self-test and as the bring-up harness for future ALU revisions.

## Interface
- `LAT`, 1: ALU result latency in clock cycles from the edge that presents a vector to the edge where `ans_i`/`ovf_i` is sampled; legal range 1..4.
- `CMD_MASK`, 8'hFF: bit k set means command k is swept; cleared commands are skipped.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; starts a sweep from IDLE or DONE.
- `cmd_o`  out  3  command to the ALU.
- `a_o`  out  4  operand a to the ALU.
- `b_o`  out  4  operand b to the ALU.
- `ans_i`  in  4  ALU result.
- `ovf_i`  in  1  ALU overflow flag.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  high in DONE.
- `pass`  out  1  valid when `done`; 1 iff `err_count` == 0.
- `err_count`  out  12  number of mismatching vectors; saturates at 4095.
- `err_valid`  out  1  a first error has been captured.
- `first_err_cmd` / `first_err_a` / `first_err_b`  out  3/4/4  first failing vector.

## Operation
- Reset value of every output is 0. The FSM resets to IDLE.
- FSM states are IDLE, RUN, DRAIN and DONE.
  - IDLE/DONE + `start` → RUN. This clears `err_count`, `err_valid`, the `first_err_*` outputs and `pass`, and loads the first enabled vector.
  - RUN issues one vector per cycle in order: cmd ascending (enabled only), then a 0..15, then b 0..15 innermost. After the last vector → DRAIN.
  - DRAIN lasts exactly LAT cycles so that all outstanding compares retire → DONE.
  - DONE holds `done`=1 until `start`.
  - `start` is ignored in RUN and DRAIN.
- If `CMD_MASK` == 0, `start` goes directly to DONE with `pass`=1 and `err_count`=0.
- The outputs `cmd_o`/`a_o`/`b_o` are registered. They hold their last value in DRAIN and DONE, and return to 0 only on reset.
- Expected results travel through a LAT-deep delay line that carries {valid, cmd, a, b, exp_ans, exp_ovf, chk_ovf}. The compare fires when the delay-line output is valid.
- Golden model, with all arithmetic in 4 bits unsigned unless stated:
  - 000 ADD: ans = (a+b) mod 16. Overflow is not checked.
  - 001 SUB: nb = (~b+1) mod 16; {ovf, ans} = 5-bit sum a + nb. Overflow is checked. For b=0, nb=0 and ovf=0.
  - 010 NOT: ans = ~a.
  - 011 AND, 100 OR, 101 XOR: bitwise.
  - 110 LT: ans = 1 if signed(a) < signed(b), else 0.
  - 111 EQ: ans = 1 if a==b, else 0.
  - Overflow is checked only for SUB.
- A mismatch is counted when ans_i ≠ exp_ans, or when chk_ovf and ovf_i ≠ exp_ovf.
  - The first mismatch latches `first_err_*` and sets `err_valid`.
  - Later mismatches only increment `err_count`.
- `pass` = (`err_count` == 0), registered on entry to DONE.

## Timing
- A vector presented after edge n is compared at edge n+LAT.
- Full sweep: the first vector appears 1 cycle after `start`. The sweep takes 256·popcount(CMD_MASK) RUN cycles plus LAT DRAIN cycles, then DONE.
  - With the default parameters, `done` rises 2048+LAT+1 cycles after the `start` edge.
- A compare retiring and the first-error capture on the same edge: the count becomes 1 and capture happens together.
- Reset asserted mid-sweep clears everything immediately and asynchronously. The delay line is flushed, so no stale compare fires after release.
- `start` arriving in the same cycle the FSM enters DONE is ignored. Only `start` seen while in DONE restarts.

## Structure
- Package `alu_pkg` holds:
  - the command localparams: CMD_ADD=3'b000 … CMD_EQ=3'b111;
  - the FSM state enum;
  - the 12-bit count width constant.
- Sub-module `alu_golden` is purely combinational: (cmd, a, b) → (exp_ans, exp_ovf, chk_ovf).
- The FSM, vector counters, delay line and error logic live in `alu_sweep_checker`.

## Test plan
- Correct ALU model, LAT=1, default mask, pulse `start` → `done` after 2050 cycles, `pass`=1, `err_count`=0, `err_valid`=0.
- SUB spot checks observed on the bus:
  - a=5, b=3 expects ans=2, ovf=1.
  - a=3, b=5 expects ans=14, ovf=0.
  - a=7, b=0 expects ans=7, ovf=0.
  - A model returning ovf=0 for a=5, b=3 → `err_count` ≥1, and the first error captured has cmd=1.
- Fault model with LT forced wrong for a=8, b=1 (expected 1) → `pass`=0, `err_count`=1, first error = {6, 8, 1}.
- LAT=3 with a 3-stage ALU model, `CMD_MASK`=8'h80 → 256 vectors, `done` at 256+3+1 cycles, `pass`=1. LAT=3 against a 1-stage model → `pass`=0.
- `rst` pulsed at cycle 500 of a sweep → all outputs 0 and IDLE. A new `start` then completes a clean full sweep with `pass`=1.
- `CMD_MASK`=0, `start` → `done`=1 on the next cycle with `pass`=1. A `start` pulsed during RUN is ignored, with no restart and an unchanged vector order.
